coffee_vending_ctrl: RTL
========================

# coffee_vending_ctrl

Sequencing controller for the coffee vending datapath. It counts inserted coins, accepts a drink selection, and qualifies that selection through the combinational price/change subtractor. It then drives a timed dispense phase and returns change one coin per cycle. It sits between the coin/keypad front end and the dispenser and coin-return actuators.

## Interface
- DISPENSE_CYCLES, 4: cycles `dispense` stays high per drink (≥1).
- MAX_COINS, 15: saturation limit of the coin counter (≤15, fits 4 bits).

- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- coin_in  in  1  single-cycle pulse, one coin unit inserted.
- sel_valid  in  1  single-cycle pulse, selection strobe.
- coffee_type  in  3  drink code, sampled when sel_valid=1: 0 expresso (3), 1 coffee & milk (4), 2 capuccino (5), 3 mocaccino (7); 4–7 invalid.
- cancel  in  1  single-cycle pulse, abort and refund all coins.
- total_coins  out  4  registered coin count.
- dispense  out  1  high for DISPENSE_CYCLES cycles.
- coin_return  out  1  one pulse per returned coin unit.
- coin_reject  out  1  one-cycle pulse, coin not accepted.
- sel_denied  out  1  one-cycle pulse, selection invalid or underfunded.
- busy  out  1  high in DISPENSE and RETURN.

## Operation
- States:
  - IDLE: total_coins=0.
  - COLLECT: total_coins>0.
  - DISPENSE.
  - RETURN.
- IDLE/COLLECT, coin_in:
  - If total_coins<MAX_COINS: total_coins+1, next state COLLECT.
  - Otherwise: coin_reject pulse, count unchanged.
- IDLE/COLLECT, sel_valid: the subtractor evaluates coffee_type against the current total_coins.
  - enable=1: latch change into the return counter, clear total_coins, go to DISPENSE.
  - enable=0: pulse sel_denied, state and count unchanged.
- IDLE/COLLECT, cancel:
  - Load total_coins into the return counter, clear total_coins.
  - Go to RETURN if the count is >0; otherwise stay in IDLE.
- Same-cycle priority: cancel > sel_valid > coin_in. Any coin_in not counted in that cycle produces a coin_reject pulse.
- DISPENSE: dispense=1 for exactly DISPENSE_CYCLES cycles. Then go to RETURN if change>0, else IDLE.
- RETURN: coin_return=1 every cycle while the return counter is >0. The counter decrements each cycle; go to IDLE after the last pulse.
- DISPENSE/RETURN: coin_in → coin_reject; sel_valid → sel_denied; cancel ignored.
- Arithmetic: all 4-bit unsigned; change = total − price, never negative (the subtractor guarantees this).

## Timing
- Reset (rst_n=0 at a clk edge): state IDLE, total_coins=0, return/dispense counters 0, all outputs 0. Reset overrides every input.
- Reset asserted mid-DISPENSE or mid-RETURN aborts immediately. The undispensed change is lost; this is a documented behaviour.
- Outputs are registered and reflect the input of the previous edge:
  - coin_in at edge N → total_coins updated after N.
  - sel_valid accepted at edge N → dispense=1 from cycle N+1 through N+DISPENSE_CYCLES.
  - The first coin_return comes in cycle N+DISPENSE_CYCLES+1; returns are back-to-back, one per cycle.
- Total latency from an accepted selection to IDLE: DISPENSE_CYCLES + change + 1 edges.
- coin_reject and sel_denied assert in the cycle after the offending input, for one cycle.

## Structure
- Shared package `vending_pkg`:
  - state enum `vend_state_t` (IDLE, COLLECT, DISPENSE, RETURN).
  - drink-code constants (EXPRESSO=0 … MOCACCINO=3).
  - price constants (3, 4, 5, 7).
- One sub-module: the existing `substractor_module`, instantiated combinationally.
  - Inputs: coffee_type, total_coins.
  - Outputs: change, enable (enable gates selection acceptance).
- Top holds the FSM, coin counter, dispense timer and return counter.

## Test plan
- Exact payment:
  - Stimulus: 3 coin_in pulses, then sel_valid with type 0.
  - Required: dispense high 4 cycles, no coin_return, back to IDLE, total_coins=0.
- Overpay:
  - Stimulus: 9 coins, then type 3.
  - Required: dispense 4 cycles, then exactly 2 consecutive coin_return pulses, then IDLE.
- Denial:
  - Stimulus: 4 coins, then type 2; separately, type 5 with 10 coins.
  - Required: sel_denied pulse each time, total_coins stays 4 and 10 respectively.
- Saturation and priority:
  - Stimulus: 16 coins.
  - Required: 16th gives coin_reject, count stays 15.
  - Stimulus: coin_in+sel_valid(type 1) in the same cycle with 4 coins.
  - Required: dispense, coin_reject, change 0.
- Cancel and reset:
  - Stimulus: 5 coins then cancel.
  - Required: 5 coin_return pulses, then IDLE.
  - Stimulus: rst_n low during the 2nd dispense cycle.
  - Required: all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared definitions for the coffee vending controller: FSM states, drink codes
// and drink prices.
package vending_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DISPENSE,
      RETURN
   } vend_state_t;

   localparam logic [2:0] EXPRESSO    = 3'd0;
   localparam logic [2:0] COFFEE_MILK = 3'd1;
   localparam logic [2:0] CAPUCCINO   = 3'd2;
   localparam logic [2:0] MOCACCINO   = 3'd3;

   localparam logic [3:0] PRICE_EXPRESSO    = 4'd3;
   localparam logic [3:0] PRICE_COFFEE_MILK = 4'd4;
   localparam logic [3:0] PRICE_CAPUCCINO   = 4'd5;
   localparam logic [3:0] PRICE_MOCACCINO   = 4'd7;

endpackage

// File: rtl/substractor_module.sv
// Combinational price/change stage: enable means the drink code is valid and
// the inserted coins cover its price; change is the remainder.
module substractor_module
   import vending_pkg::*;
(
   input  logic [2:0] coffee_type,
   input  logic [3:0] total_coins,
   output logic [3:0] change,
   output logic       enable
);

   logic [3:0] price;
   logic       known;

   always_comb begin
      price = '0;
      known = 1'b1;
      case (coffee_type)
         EXPRESSO:    price = PRICE_EXPRESSO;
         COFFEE_MILK: price = PRICE_COFFEE_MILK;
         CAPUCCINO:   price = PRICE_CAPUCCINO;
         MOCACCINO:   price = PRICE_MOCACCINO;
         default:     known = 1'b0;
      endcase
      enable = known && (total_coins >= price);
      change = enable ? (total_coins - price) : '0;
   end

endmodule

// File: rtl/coffee_vending_ctrl.sv
// Vending sequencer: coin counting, selection qualification, timed dispense and
// one-coin-per-cycle change return. All outputs except busy are registered.
module coffee_vending_ctrl
   import vending_pkg::*;
#(
   parameter int unsigned DISPENSE_CYCLES = 4,
   parameter int unsigned MAX_COINS       = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       coin_in,
   input  logic       sel_valid,
   input  logic [2:0] coffee_type,
   input  logic       cancel,
   output logic [3:0] total_coins,
   output logic       dispense,
   output logic       coin_return,
   output logic       coin_reject,
   output logic       sel_denied,
   output logic       busy
);

   localparam int unsigned DW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

   vend_state_t   state, state_nxt;
   logic [3:0]    total_nxt;
   logic [3:0]    ret_cnt, ret_nxt;
   logic [DW-1:0] disp_cnt, disp_nxt;
   logic          dispense_nxt, coin_return_nxt, coin_reject_nxt, sel_denied_nxt;
   logic [3:0]    change;
   logic          enable;

   substractor_module u_sub (
      .coffee_type (coffee_type),
      .total_coins (total_coins),
      .change      (change),
      .enable      (enable)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         total_coins <= '0;
         ret_cnt     <= '0;
         disp_cnt    <= '0;
         dispense    <= 1'b0;
         coin_return <= 1'b0;
         coin_reject <= 1'b0;
         sel_denied  <= 1'b0;
      end else begin
         state       <= state_nxt;
         total_coins <= total_nxt;
         ret_cnt     <= ret_nxt;
         disp_cnt    <= disp_nxt;
         dispense    <= dispense_nxt;
         coin_return <= coin_return_nxt;
         coin_reject <= coin_reject_nxt;
         sel_denied  <= sel_denied_nxt;
      end
   end

   // ret_cnt holds the coins still owed after the pulse currently being driven,
   // so the first pulse is issued on the same edge that enters RETURN.
   always_comb begin
      state_nxt       = state;
      total_nxt       = total_coins;
      ret_nxt         = ret_cnt;
      disp_nxt        = disp_cnt;
      dispense_nxt    = 1'b0;
      coin_return_nxt = 1'b0;
      coin_reject_nxt = 1'b0;
      sel_denied_nxt  = 1'b0;
      case (state)
         IDLE, COLLECT: begin
            if (cancel) begin
               coin_reject_nxt = coin_in;
               total_nxt       = '0;
               if (total_coins != '0) begin
                  state_nxt       = RETURN;
                  coin_return_nxt = 1'b1;
                  ret_nxt         = total_coins - 4'd1;
               end else begin
                  state_nxt = IDLE;
                  ret_nxt   = '0;
               end
            end else if (sel_valid) begin
               coin_reject_nxt = coin_in;
               if (enable) begin
                  ret_nxt      = change;
                  total_nxt    = '0;
                  state_nxt    = DISPENSE;
                  dispense_nxt = 1'b1;
                  disp_nxt     = DW'(DISPENSE_CYCLES - 1);
               end else begin
                  sel_denied_nxt = 1'b1;
               end
            end else if (coin_in) begin
               if (total_coins < 4'(MAX_COINS)) begin
                  total_nxt = total_coins + 4'd1;
                  state_nxt = COLLECT;
               end else begin
                  coin_reject_nxt = 1'b1;
               end
            end
         end
         DISPENSE: begin
            coin_reject_nxt = coin_in;
            sel_denied_nxt  = sel_valid;
            if (disp_cnt != '0) begin
               disp_nxt     = disp_cnt - DW'(1);
               dispense_nxt = 1'b1;
            end else if (ret_cnt != '0) begin
               state_nxt       = RETURN;
               coin_return_nxt = 1'b1;
               ret_nxt         = ret_cnt - 4'd1;
            end else begin
               state_nxt = IDLE;
            end
         end
         RETURN: begin
            coin_reject_nxt = coin_in;
            sel_denied_nxt  = sel_valid;
            if (ret_cnt != '0) begin
               coin_return_nxt = 1'b1;
               ret_nxt         = ret_cnt - 4'd1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == DISPENSE) || (state == RETURN);

endmodule
